// File: rtl/pwm4_gen.sv
// Four-channel PWM generator: prescaled up-counter compared against four
// double-buffered compare registers, configured through a small register port.
module pwm4_gen #(
  parameter int CNT_W   = 16,
  parameter int SCALE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_wen,
  input  logic [2:0]       reg_addr,
  input  logic [CNT_W-1:0] reg_wdata,
  output logic [CNT_W-1:0] reg_rdata,
  output logic             pwm_port_0,
  output logic             pwm_port_1,
  output logic             pwm_port_2,
  output logic             pwm_port_3,
  output logic             wrap_pulse
);

  localparam int PRE_W = (1 << SCALE_W) - 1;

  logic               en;
  logic               zerocmp;
  logic               oneshot;
  logic [SCALE_W-1:0] scale;
  logic [PRE_W-1:0]   pre;
  logic [PRE_W-1:0]   pre_max;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   pend [4];
  logic [CNT_W-1:0]   act  [4];
  logic [3:0]         ip;
  logic [3:0]         pwm_q;
  logic [3:0]         pwm_d;
  logic [3:0]         cmp_wr;
  logic               wr_cfg;
  logic               wr_cnt;
  logic               wr_ip;
  logic               tick;
  logic               wrap;
  logic               wrap_evt;

  assign wr_cfg = reg_wen && (reg_addr == 3'd0);
  assign wr_cnt = reg_wen && (reg_addr == 3'd1);
  assign wr_ip  = reg_wen && (reg_addr == 3'd6);

  // Terminal prescaler value 2^scale-1; a shift of all ones keeps it width-safe up to scale=15.
  assign pre_max  = ~({PRE_W{1'b1}} << scale);
  assign tick     = en && (pre == pre_max);
  assign wrap     = (cnt == {CNT_W{1'b1}}) || (zerocmp && (cnt >= act[0]));
  assign wrap_evt = tick && wrap;

  always_comb begin
    pwm_d  = '0;
    cmp_wr = '0;
    for (int i = 0; i < 4; i++) begin
      pwm_d[i]  = (cnt >= act[i]);
      cmp_wr[i] = reg_wen && (reg_addr == 3'(i + 2));
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0: begin
        reg_rdata[0]             = en;
        reg_rdata[1]             = zerocmp;
        reg_rdata[2]             = oneshot;
        reg_rdata[4 +: SCALE_W]  = scale;
      end
      3'd1:    reg_rdata = cnt;
      3'd2:    reg_rdata = pend[0];
      3'd3:    reg_rdata = pend[1];
      3'd4:    reg_rdata = pend[2];
      3'd5:    reg_rdata = pend[3];
      3'd6:    reg_rdata[3:0] = ip;
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en         <= 1'b0;
      zerocmp    <= 1'b0;
      oneshot    <= 1'b0;
      scale      <= '0;
      pre        <= '0;
      cnt        <= '0;
      ip         <= '0;
      pwm_q      <= '0;
      wrap_pulse <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pend[i] <= {CNT_W{1'b1}};
        act[i]  <= {CNT_W{1'b1}};
      end
    end else begin
      if (wr_cnt || !en || tick)
        pre <= '0;
      else
        pre <= pre + PRE_W'(1);

      // A COUNT write overrides the tick's increment.
      if (wr_cnt)
        cnt <= reg_wdata;
      else if (tick)
        cnt <= wrap ? '0 : cnt + CNT_W'(1);

      if (wr_cfg) begin
        en      <= reg_wdata[0];
        zerocmp <= reg_wdata[1];
        oneshot <= reg_wdata[2];
        scale   <= reg_wdata[4 +: SCALE_W];
      end else if (wrap_evt && oneshot) begin
        en <= 1'b0;
      end

      // While stopped, or on the wrap itself, a compare write lands in the active copy too.
      for (int i = 0; i < 4; i++) begin
        if (wrap_evt)
          act[i] <= pend[i];
        if (cmp_wr[i]) begin
          pend[i] <= reg_wdata;
          if (!en || wrap_evt)
            act[i] <= reg_wdata;
        end
      end

      ip         <= (wr_ip ? (ip & ~reg_wdata[3:0]) : ip) | (pwm_d & ~pwm_q);
      pwm_q      <= pwm_d;
      wrap_pulse <= wrap_evt;
    end
  end

  assign pwm_port_0 = pwm_q[0];
  assign pwm_port_1 = pwm_q[1];
  assign pwm_port_2 = pwm_q[2];
  assign pwm_port_3 = pwm_q[3];

endmodule

// File: tb/tb_pwm4_gen.sv
// Directed bench for pwm4_gen: per-cycle expectations of the PWM outputs and
// wrap pulse are queued ahead of each run and checked as the DUT produces them.
module tb_pwm4_gen;

  logic        clk;
  logic        rst_n;
  logic        reg_wen;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        pwm_port_0, pwm_port_1, pwm_port_2, pwm_port_3;
  logic        wrap_pulse;

  typedef struct packed {
    logic [3:0] pwm;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   c;
  int   a1;

  pwm4_gen #(.CNT_W(16), .SCALE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_wen    (reg_wen),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .pwm_port_0 (pwm_port_0),
    .pwm_port_1 (pwm_port_1),
    .pwm_port_2 (pwm_port_2),
    .pwm_port_3 (pwm_port_3),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] pwm_now();
    return {pwm_port_3, pwm_port_2, pwm_port_1, pwm_port_0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic w);
    sb.push_back({p, w});
  endtask

  task automatic cmp_now();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_empty observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("pwm_wrap", 16'({pwm_now(), wrap_pulse}), 16'(e));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_now();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    reg_wen   = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_wen   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    reg_wen   = 1'b0;
    reg_addr  = 3'd0;
    reg_wdata = 16'h0;

    // Reset state
    @(negedge clk);
    chk("rst_pwm", 16'({pwm_now(), wrap_pulse}), 16'h0);
    rd(3'd0, 16'h0000, "rst_cfg");
    rd(3'd2, 16'hFFFF, "rst_cmp0");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pwm", 16'({pwm_now(), wrap_pulse}), 16'h0);
    rd(3'd1, 16'h0000, "rst_count");
    rd(3'd6, 16'h0000, "rst_ip");
    wr(3'd7, 16'hABCD);
    rd(3'd7, 16'h0000, "reserved");
    wr(3'd0, 16'hFF08);
    rd(3'd0, 16'h0000, "cfg_unused_bits");

    // Basic period: 5 cycles, ch0 high 1/5, ch1 high 3/5
    wr(3'd2, 16'd4);
    wr(3'd3, 16'd2);
    for (int k = 1; k <= 10; k++) begin
      c = (k - 1) % 5;
      push({2'b00, c >= 2, c >= 4}, c == 4);
    end
    wr(3'd0, 16'h0003);
    rd(3'd0, 16'h0003, "cfg_readback");
    step(10);

    // Prescale by 4: 20-cycle period
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0000);
    for (int k = 1; k <= 24; k++) begin
      c = ((k - 1) % 20) / 4;
      push({2'b00, c >= 2, c >= 4}, ((k - 1) % 20) == 19);
    end
    wr(3'd0, 16'h0023);
    step(24);

    // Shadow update of CMP1 at cnt=1
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0000);
    wr(3'd3, 16'd2);
    for (int k = 1; k <= 10; k++) begin
      c  = (k - 1) % 5;
      a1 = (k <= 5) ? 2 : 4;
      push({2'b00, c >= a1, c >= 4}, c == 4);
    end
    wr(3'd0, 16'h0003);
    step(1);
    rd(3'd1, 16'h0001, "shadow_cnt1");
    wr(3'd3, 16'd4);
    cmp_now();
    rd(3'd3, 16'd4, "shadow_cmp1_rd");
    step(8);

    // Oneshot: single wrap after 4 cycles, then stopped
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'd3);
    for (int k = 1; k <= 10; k++) begin
      c = (k <= 4) ? k - 1 : 0;
      push({3'b000, c >= 3}, k == 4);
    end
    wr(3'd0, 16'h0007);
    step(10);
    rd(3'd0, 16'h0006, "oneshot_cfg");
    rd(3'd1, 16'h0000, "oneshot_cnt");

    // Full-range wrap, zerocmp off
    wr(3'd6, 16'h000F);
    rd(3'd6, 16'h0000, "ip_cleared");
    wr(3'd4, 16'h0000);
    wr(3'd1, 16'hFFFE);
    for (int k = 1; k <= 6; k++) begin
      c = (k == 1) ? 32'hFFFE : (k == 2) ? 32'hFFFF : k - 3;
      push({c == 32'hFFFF, 1'b1, c >= 4, c >= 3}, k == 2);
    end
    wr(3'd0, 16'h0001);
    step(1);
    rd(3'd1, 16'hFFFF, "full_cnt_ffff");
    step(1);
    rd(3'd1, 16'h0000, "full_cnt_wrap");
    step(4);
    rd(3'd6, 16'h000F, "full_ip");

    // IP clear, then clear colliding with a rise, then reset mid-period
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'd4);
    wr(3'd0, 16'h0003);
    wr(3'd6, 16'h0001);
    rd(3'd6, 16'h000E, "ip_w1c");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    wr(3'd6, 16'h0001);
    chk("rise_pwm0", 16'(pwm_port_0), 16'h1);
    rd(3'd6, 16'h000F, "ip_set_wins");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 16'({pwm_now(), wrap_pulse}), 16'h0);
    rd(3'd0, 16'h0000, "midrst_cfg");
    rd(3'd6, 16'h0000, "midrst_ip");
    @(negedge clk);
    rd(3'd2, 16'hFFFF, "midrst_cmp0");
    rd(3'd1, 16'h0000, "midrst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) push(4'b0000, 1'b0);
    step(4);

    // act0=0 with zerocmp: wrap every tick, ch0 constantly high
    wr(3'd2, 16'h0000);
    for (int k = 1; k <= 6; k++) push(4'b0001, 1'b1);
    wr(3'd0, 16'h0003);
    step(6);
    rd(3'd1, 16'h0000, "zero_cmp_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
